// File: rtl/fetch_unit_if.sv
// Instruction-memory request/response bus between the fetch unit and imem.
// Latency: n/a (wiring only).
// Backpressure: imem_gnt acknowledges a request; imem_rvalid returns its data.
//
// Ports (signals):
//   imem_req / imem_addr : request from fetch (master) to memory (slave)
//   imem_gnt             : request accepted this cycle
//   imem_rvalid / imem_rdata : read response
interface fetch_unit_if #(
    parameter int ADDR_W  = 32,
    parameter int INSTR_W = 128
) ();
    logic               imem_req;
    logic [ADDR_W-1:0]  imem_addr;
    logic               imem_gnt;
    logic               imem_rvalid;
    logic [INSTR_W-1:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_gnt,
        input  imem_rvalid,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_gnt,
        output imem_rvalid,
        output imem_rdata
    );
endinterface

// File: rtl/fetch_unit.sv
// Single-outstanding instruction fetch FSM with stall buffer and redirect drain.
// Latency: instr_valid pulses the cycle after imem_rvalid (or after stall drops).
// Backpressure: stall parks the returned word in a one-entry buffer; no new request meanwhile.
//
// Ports:
//   clk, rstn            : clock, async active-low reset
//   stall                : decode not accepting, hold fetched instruction
//   redirect/redirect_pc : branch/jump redirect pulse and target
//   imem (master)        : imem_req/imem_addr out, imem_gnt/imem_rvalid/imem_rdata in
//   instr_f/instr_valid  : delivered instruction and its one-cycle enable
//   pc_f                 : current fetch PC
module fetch_unit #(
    parameter int                ADDR_W   = 32,
    parameter int                INSTR_W  = 128,
    parameter int                PC_STEP  = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               stall,
    input  logic               redirect,
    input  logic [ADDR_W-1:0]  redirect_pc,
    fetch_unit_if.master       imem,
    output logic [INSTR_W-1:0] instr_f,
    output logic               instr_valid,
    output logic [ADDR_W-1:0]  pc_f
);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] REQ   = 3'd1;
    localparam logic [2:0] WAIT  = 3'd2;
    localparam logic [2:0] HOLD  = 3'd3;
    localparam logic [2:0] DRAIN = 3'd4;

    logic [2:0]         state_q, state_d;
    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic [INSTR_W-1:0] instr_q, instr_d;
    logic               vld_q, vld_d;
    logic [INSTR_W-1:0] buf_q, buf_d;

    logic [ADDR_W-1:0]  pc_next;

    // Wraps modulo 2^ADDR_W by construction.
    assign pc_next = pc_q + ADDR_W'(PC_STEP);

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        vld_d   = 1'b0;
        buf_d   = buf_q;

        if (redirect) begin
            pc_d  = redirect_pc;
            buf_d = '0;
            case (state_q)
                IDLE, HOLD: state_d = REQ;
                // A grant in the redirect cycle leaves a response in flight.
                REQ:        state_d = imem.imem_gnt ? DRAIN : REQ;
                // A response arriving with the redirect closes the transaction;
                // draining would wait for data that never comes.
                WAIT:       state_d = imem.imem_rvalid ? REQ : DRAIN;
                DRAIN:      state_d = imem.imem_rvalid ? REQ : DRAIN;
                default:    state_d = IDLE;
            endcase
        end else begin
            case (state_q)
                IDLE: state_d = REQ;
                REQ: begin
                    if (imem.imem_gnt) state_d = WAIT;
                end
                WAIT: begin
                    if (imem.imem_rvalid) begin
                        if (stall) begin
                            buf_d   = imem.imem_rdata;
                            state_d = HOLD;
                        end else begin
                            instr_d = imem.imem_rdata;
                            vld_d   = 1'b1;
                            pc_d    = pc_next;
                            state_d = REQ;
                        end
                    end
                end
                HOLD: begin
                    if (!stall) begin
                        instr_d = buf_q;
                        vld_d   = 1'b1;
                        pc_d    = pc_next;
                        state_d = REQ;
                    end
                end
                DRAIN: begin
                    if (imem.imem_rvalid) state_d = REQ;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
            pc_q    <= RESET_PC;
            instr_q <= '0;
            vld_q   <= 1'b0;
            buf_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            vld_q   <= vld_d;
            buf_q   <= buf_d;
        end
    end

    assign imem.imem_req  = (state_q == REQ);
    assign imem.imem_addr = pc_q;
    assign instr_f        = instr_q;
    assign instr_valid    = vld_q;
    assign pc_f           = pc_q;

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

    logic         clk;
    logic         rstn;
    logic         stall;
    logic         redirect;
    logic [31:0]  redirect_pc;
    logic [127:0] instr_f;
    logic         instr_valid;
    logic [31:0]  pc_f;

    fetch_unit_if #(.ADDR_W(32), .INSTR_W(128)) imem ();

    fetch_unit #(
        .ADDR_W   (32),
        .INSTR_W  (128),
        .PC_STEP  (16),
        .RESET_PC (32'h0)
    ) dut (
        .clk         (clk),
        .rstn        (rstn),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .imem        (imem.master),
        .instr_f     (instr_f),
        .instr_valid (instr_valid),
        .pc_f        (pc_f)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [127:0] instr;
        logic [31:0]  pc_after;
    } deliv_t;

    deliv_t      exp_deliv_q[$];
    logic [31:0] exp_addr_q[$];

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: compares granted addresses and delivered instructions against the scoreboards.
    always @(negedge clk) begin
        if (rstn) begin
            if (imem.imem_req && imem.imem_gnt) begin
                if (exp_addr_q.size() == 0) begin
                    n_cmp++; n_err++;
                    $display("FAIL unexpected_grant: addr %h with nothing expected", imem.imem_addr);
                end else begin
                    check("grant_addr", 128'(imem.imem_addr), 128'(exp_addr_q.pop_front()));
                end
            end
            if (instr_valid) begin
                if (exp_deliv_q.size() == 0) begin
                    n_cmp++; n_err++;
                    $display("FAIL unexpected_instr_valid: instr %h with nothing expected", instr_f);
                end else begin
                    deliv_t e;
                    e = exp_deliv_q.pop_front();
                    check("instr_f", instr_f, e.instr);
                    check("pc_after_delivery", 128'(pc_f), 128'(e.pc_after));
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_req();
        int n = 0;
        while (!imem.imem_req && n < 50) begin
            tick();
            n++;
        end
        if (!imem.imem_req) begin
            n_cmp++; n_err++;
            $display("FAIL req_timeout: imem_req 0 after 50 cycles, expected 1");
        end
    endtask

    // Withhold grant for 'delay' cycles (request must stay up, address stable), then grant.
    task automatic grant(input int delay, input logic [31:0] exp_addr);
        wait_req();
        for (int i = 0; i < delay; i++) begin
            check("req_held", 128'(imem.imem_req), 128'(1'b1));
            check("addr_stable", 128'(imem.imem_addr), 128'(exp_addr));
            tick();
        end
        exp_addr_q.push_back(exp_addr);
        imem.imem_gnt = 1'b1;
        tick();
        imem.imem_gnt = 1'b0;
    endtask

    // Return data; stall_cyc>0 keeps stall high for that many cycles starting at rvalid.
    task automatic respond(input logic [127:0] data, input int stall_cyc, input logic [31:0] pc_after);
        deliv_t e;
        e.instr    = data;
        e.pc_after = pc_after;
        imem.imem_rvalid = 1'b1;
        imem.imem_rdata  = data;
        stall            = (stall_cyc > 0);
        if (stall_cyc == 0) exp_deliv_q.push_back(e);
        tick();
        imem.imem_rvalid = 1'b0;
        imem.imem_rdata  = '1;
        if (stall_cyc > 0) begin
            for (int i = 1; i < stall_cyc; i++) begin
                check("no_req_in_hold", 128'(imem.imem_req), 128'(1'b0));
                tick();
            end
            check("no_req_in_hold", 128'(imem.imem_req), 128'(1'b0));
            exp_deliv_q.push_back(e);
            stall = 1'b0;
            tick();
        end
    endtask

    initial begin
        rstn             = 1'b0;
        stall            = 1'b0;
        redirect         = 1'b0;
        redirect_pc      = '0;
        imem.imem_gnt    = 1'b0;
        imem.imem_rvalid = 1'b0;
        imem.imem_rdata  = '0;

        repeat (3) tick();
        check("rst_pc_f", 128'(pc_f), 128'(32'h0));
        check("rst_instr_f", instr_f, 128'h0);
        check("rst_instr_valid", 128'(instr_valid), 128'(1'b0));
        check("rst_imem_req", 128'(imem.imem_req), 128'(1'b0));

        // One IDLE cycle after release, then REQ.
        rstn = 1'b1;
        check("idle_no_req", 128'(imem.imem_req), 128'(1'b0));
        tick();
        check("req_after_idle", 128'(imem.imem_req), 128'(1'b1));
        check("first_addr", 128'(imem.imem_addr), 128'(32'h0));

        // Basic fetch: immediate grant, data next cycle.
        grant(0, 32'h0);
        respond(128'hAAAA_0001_AAAA_0002_AAAA_0003_AAAA_0004, 0, 32'h10);

        // Grant withheld three cycles.
        grant(3, 32'h10);
        respond(128'h2222_2222_2222_2222_2222_2222_2222_2222, 0, 32'h20);

        // Stall for four cycles at data return.
        grant(0, 32'h20);
        respond(128'hBBBB_0001_BBBB_0002_BBBB_0003_BBBB_0004, 4, 32'h30);

        // Redirect in WAIT: response dropped, next fetch from target.
        grant(0, 32'h30);
        redirect    = 1'b1;
        redirect_pc = 32'h200;
        tick();
        redirect = 1'b0;
        check("pc_after_redirect", 128'(pc_f), 128'(32'h200));
        check("drain_no_req", 128'(imem.imem_req), 128'(1'b0));
        imem.imem_rvalid = 1'b1;
        imem.imem_rdata  = 128'hDEAD_DEAD_DEAD_DEAD_DEAD_DEAD_DEAD_DEAD;
        tick();
        imem.imem_rvalid = 1'b0;
        grant(0, 32'h200);
        respond(128'hD000_0000_0000_0000_0000_0000_0000_000D, 0, 32'h210);

        // Redirect coinciding with rvalid in WAIT: straight back to REQ.
        grant(0, 32'h210);
        redirect         = 1'b1;
        redirect_pc      = 32'h300;
        imem.imem_rvalid = 1'b1;
        imem.imem_rdata  = 128'hBAD0_BAD0_BAD0_BAD0_BAD0_BAD0_BAD0_BAD0;
        tick();
        redirect         = 1'b0;
        imem.imem_rvalid = 1'b0;
        check("req_after_redirect_rvalid", 128'(imem.imem_req), 128'(1'b1));
        check("addr_after_redirect_rvalid", 128'(imem.imem_addr), 128'(32'h300));
        grant(0, 32'h300);
        respond(128'hE000_0000_0000_0000_0000_0000_0000_000E, 0, 32'h310);

        // Redirect in REQ without grant, then PC wrap on delivery.
        wait_req();
        redirect    = 1'b1;
        redirect_pc = 32'hFFFF_FFF0;
        tick();
        redirect = 1'b0;
        check("wrap_req", 128'(imem.imem_req), 128'(1'b1));
        check("wrap_addr", 128'(imem.imem_addr), 128'(32'hFFFF_FFF0));
        grant(0, 32'hFFFF_FFF0);
        respond(128'hF000_0000_0000_0000_0000_0000_0000_000F, 0, 32'h0);
        check("wrapped_pc", 128'(pc_f), 128'(32'h0));

        // Reset pulse while WAITing; late rvalid ignored afterwards.
        grant(0, 32'h0);
        rstn = 1'b0;
        #1;
        check("async_rst_instr_f", instr_f, 128'h0);
        check("async_rst_pc_f", 128'(pc_f), 128'(32'h0));
        check("async_rst_req", 128'(imem.imem_req), 128'(1'b0));
        check("async_rst_valid", 128'(instr_valid), 128'(1'b0));
        tick();
        rstn             = 1'b1;
        imem.imem_rvalid = 1'b1;
        imem.imem_rdata  = 128'h1A7E_1A7E_1A7E_1A7E_1A7E_1A7E_1A7E_1A7E;
        check("post_rst_idle", 128'(imem.imem_req), 128'(1'b0));
        tick();
        check("post_rst_req", 128'(imem.imem_req), 128'(1'b1));
        check("post_rst_addr", 128'(imem.imem_addr), 128'(32'h0));
        tick();
        imem.imem_rvalid = 1'b0;
        grant(0, 32'h0);
        respond(128'h6666_0000_0000_0000_0000_0000_0000_6666, 0, 32'h10);

        repeat (3) tick();
        check("deliv_queue_empty", 128'(exp_deliv_q.size()), 128'(0));
        check("addr_queue_empty", 128'(exp_addr_q.size()), 128'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter ADDR_W, default 32, PC/address width.
REQ-002 Parameter INSTR_W, default 128, instruction word width.
REQ-003 Parameter PC_STEP, default 16, PC increment per instruction in bytes.
REQ-004 Parameter RESET_PC, default 0, PC value loaded at reset.
REQ-005 The block SHALL provide these ports; clock and reset use the codebase names clk and rstn, one clock, reset asynchronous active-low:
- clk  in  1  rising-edge clock
- rstn  in  1  async active-low reset
- stall  in  1  decode side not accepting; holds fetched instruction
- redirect  in  1  branch/jump redirect pulse
- redirect_pc  in  ADDR_W  target PC, valid with redirect
- imem_req  out  1  instruction memory request
- imem_addr  out  ADDR_W  request address (equals pc_f)
- imem_gnt  in  1  request accepted this cycle
- imem_rvalid  in  1  read data valid
- imem_rdata  in  INSTR_W  read data
- instr_f  out  INSTR_W  instruction to fetch/decode register
- instr_valid  out  1  one-cycle pulse; drives fetch/decode register enable
- pc_f  out  ADDR_W  current fetch PC

Function
REQ-006 FSM states SHALL be IDLE, REQ, WAIT, HOLD, DRAIN; all outputs registered except imem_req and imem_addr, which decode from state and pc_f.
REQ-007 IDLE SHALL last exactly one cycle after reset deassertion, then go to REQ.
REQ-008 In REQ, imem_req SHALL be 1 and imem_addr SHALL equal pc_f; imem_req SHALL be 0 in every other state.
REQ-009 REQ with imem_gnt=1 SHALL move to WAIT; with imem_gnt=0 it SHALL stay in REQ with address stable.
REQ-010 At most one request SHALL be outstanding; no new request until its response returns or is drained.
REQ-011 WAIT with imem_rvalid=1 and stall=0 SHALL load instr_f<=imem_rdata, pulse instr_valid=1 next cycle, set pc_f<=pc_f+PC_STEP, go to REQ.
REQ-012 WAIT with imem_rvalid=1 and stall=1 SHALL capture imem_rdata in an internal buffer and go to HOLD; instr_valid stays 0.
REQ-013 HOLD with stall=0 SHALL load instr_f from the buffer, pulse instr_valid, advance pc_f by PC_STEP, and go to REQ; HOLD with stall=1 SHALL stay.
REQ-014 instr_valid SHALL be 1 for exactly one cycle per delivered instruction and 0 otherwise; instr_f SHALL hold its last value between deliveries.
REQ-015 redirect SHALL have priority over all other events: pc_f<=redirect_pc, instr_valid<=0, and any buffered (HOLD) instruction discarded.
REQ-016 Redirect next state: from IDLE/REQ (no gnt same cycle)/HOLD -> REQ; from WAIT, DRAIN, or REQ with gnt same cycle -> DRAIN.
REQ-017 A WAIT-state imem_rvalid coinciding with redirect SHALL be discarded and SHALL go to REQ, not DRAIN.
REQ-018 DRAIN SHALL ignore imem_rdata, wait for imem_rvalid, then go to REQ; further redirects in DRAIN update pc_f only.
REQ-019 PC arithmetic SHALL be modulo 2^ADDR_W (wrap silently).
REQ-020 imem_rvalid outside WAIT/DRAIN SHALL be ignored.

Reset
REQ-021 When rstn=0, asynchronously: state=IDLE, pc_f=RESET_PC, instr_f=0, instr_valid=0, buffer=0, imem_req=0.
REQ-022 Reset asserted mid-transaction SHALL abandon the outstanding request; no drain after reset.

Verification
REQ-023 Reset then gnt immediate, rvalid one cycle later with rdata=A, stall=0 -> imem_addr=0x0, instr_f=A, one instr_valid pulse, next imem_addr=0x10.
REQ-024 gnt withheld 3 cycles -> imem_req held high, imem_addr stable at 0x0, no instr_valid.
REQ-025 rvalid with rdata=B while stall=1 for 4 cycles -> instr_valid=0 during stall, instr_f=B with one pulse the cycle after stall drops, no new request during HOLD.
REQ-026 redirect to 0x200 while in WAIT -> next rvalid data dropped (no instr_valid), following imem_addr=0x200.
REQ-027 pc_f=0xFFFFFFF0, delivery -> pc_f=0x00000000.
REQ-028 rstn pulsed low during WAIT -> outputs at reset values immediately, IDLE then REQ at 0x0, late rvalid ignored.
